// File: rtl/conv_window_gen_if.sv
// conv_window_gen_if
//   Pixel-in / window-out bundle for the 3x3 window generator.
//   master : pixel source (drives i_valid, i_pixel, i_sof), sees window outputs.
//   slave  : the window generator.
//   Signals:
//     i_valid   pixel qualifier (no backpressure)
//     i_pixel   NB_DATA-bit pixel, raster order
//     i_sof     start of frame, only when CONV_WINDOW_SOF_EN is defined
//     o_valid   o_window carries a new complete window
//     o_window  NB_DATA*KERNEL_SIZE packed window, element 1 in the MSBs
//     o_last    final window of the frame
interface conv_window_gen_if #(
    parameter int NB_DATA     = 8,
    parameter int KERNEL_SIZE = 9
);
    logic                            i_valid;
    logic [NB_DATA-1:0]              i_pixel;
`ifdef CONV_WINDOW_SOF_EN
    logic                            i_sof;
`endif
    logic                            o_valid;
    logic [NB_DATA*KERNEL_SIZE-1:0]  o_window;
    logic                            o_last;

    modport master (
`ifdef CONV_WINDOW_SOF_EN
        output i_sof,
`endif
        output i_valid, i_pixel,
        input  o_valid, o_window, o_last
    );

    modport slave (
`ifdef CONV_WINDOW_SOF_EN
        input  i_sof,
`endif
        input  i_valid, i_pixel,
        output o_valid, o_window, o_last
    );
endinterface

// File: rtl/conv_window_gen.sv
// conv_window_gen
//   Streaming 3x3 window generator. Takes a raster-order pixel stream, keeps
//   two previous lines in line buffers and emits a packed 3x3 window for every
//   pixel at row >= 2, col >= 2 (no padding).
//   Ports:
//     clk      single clock, posedge
//     i_rst_n  asynchronous active-low reset
//     bus      conv_window_gen_if.slave (i_valid, i_pixel, [i_sof],
//              o_valid, o_window, o_last)
//   Optional feature: define CONV_WINDOW_SOF_EN to add i_sof, which forces
//   the accepted pixel to position (0,0) and resynchronises the counters.
//   Window layout: element k (1..9) at bits [NB_DATA*(10-k)-1 -: NB_DATA],
//   row-major, top-left first, element 9 = newest pixel.

// One window row: three taps, oldest in taps[2], newest in taps[0], so the
// packed value reads oldest..newest from MSB to LSB.
module conv_window_row #(
    parameter int NB_DATA = 8
) (
    input  logic                    clk,
    input  logic                    i_rst_n,
    input  logic                    en,
    input  logic [NB_DATA-1:0]      din,
    output logic [2:0][NB_DATA-1:0] taps
);
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) taps <= '0;
        else if (en)  taps <= {taps[1:0], din};
    end
endmodule

module conv_window_gen #(
    parameter int NB_DATA     = 8,
    parameter int IMG_WIDTH   = 64,
    parameter int IMG_HEIGHT  = 64,
    parameter int KERNEL_SIZE = 9
) (
    input  logic              clk,
    input  logic              i_rst_n,
    conv_window_gen_if.slave  bus
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(2);
    localparam logic [RW-1:0] ROW_MIN  = RW'(2);

    if (KERNEL_SIZE != 9) begin : g_bad_kernel
        $error("conv_window_gen: KERNEL_SIZE must be 9");
    end
    if (IMG_WIDTH < 3 || IMG_HEIGHT < 3) begin : g_bad_dims
        $error("conv_window_gen: IMG_WIDTH and IMG_HEIGHT must be >= 3");
    end

    logic                     accept;
    logic                     sof;
    logic [CW-1:0]            col, pos_col;
    logic [RW-1:0]            row, pos_row;
    logic                     win_pos, last_pos;
    logic [NB_DATA-1:0]       lb0 [IMG_WIDTH];
    logic [NB_DATA-1:0]       lb1 [IMG_WIDTH];
    logic [2:0][NB_DATA-1:0]  col_in;
    logic [2:0][2:0][NB_DATA-1:0] win;   // [2]=top, [1]=mid, [0]=bottom
    logic                     valid_q, last_q;

    assign accept = bus.i_valid;
`ifdef CONV_WINDOW_SOF_EN
    assign sof = bus.i_sof;
`else
    assign sof = 1'b0;
`endif

    // Position of the pixel being accepted this cycle; SOF overrides the
    // counters so the pixel lands at (0,0) whatever state they were in.
    assign pos_col  = sof ? '0 : col;
    assign pos_row  = sof ? '0 : row;
    assign win_pos  = (pos_row >= ROW_MIN) && (pos_col >= COL_MIN);
    assign last_pos = (pos_row == ROW_LAST) && (pos_col == COL_LAST);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (pos_col == COL_LAST) begin
                col <= '0;
                row <= (pos_row == ROW_LAST) ? '0 : pos_row + RW'(1);
            end else begin
                col <= pos_col + CW'(1);
                row <= pos_row;
            end
        end
    end

    // Line buffers hold no reset: stale contents only ever reach windows at
    // row < 2 or col < 2, which are never flagged valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[pos_col] <= lb0[pos_col];
            lb0[pos_col] <= bus.i_pixel;
        end
    end

    assign col_in[2] = lb1[pos_col];
    assign col_in[1] = lb0[pos_col];
    assign col_in[0] = bus.i_pixel;

    for (genvar r = 0; r < 3; r++) begin : g_row
        conv_window_row #(.NB_DATA(NB_DATA)) u_row (
            .clk     (clk),
            .i_rst_n (i_rst_n),
            .en      (accept),
            .din     (col_in[r]),
            .taps    (win[r])
        );
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= accept && win_pos;
            last_q  <= accept && win_pos && last_pos;
        end
    end

    assign bus.o_valid  = valid_q;
    assign bus.o_last   = last_q;
    assign bus.o_window = win;
endmodule

// File: tb/tb_conv_window_gen.sv
module tb_conv_window_gen;
    localparam int NB = 8;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int K  = 9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conv_window_gen_if #(.NB_DATA(NB), .KERNEL_SIZE(K)) bus ();

    conv_window_gen #(.NB_DATA(NB), .IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL_SIZE(K)) dut (
        .clk     (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: the current frame as a 2D image, plus the position the
    // next accepted pixel will take.
    logic [NB-1:0]   img [H][W];
    int              mr, mc;
    logic            exp_valid, exp_last, win_known;
    logic [NB*K-1:0] exp_win;
    int              nwin;
    logic [NB*K-1:0] cap [$];

    task automatic chk(input string name, input logic [NB*K-1:0] act, input logic [NB*K-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [NB*K-1:0] model_win(input int r, input int c);
        logic [NB*K-1:0] w = '0;
        for (int k = 1; k <= 9; k++)
            w[NB*(10-k)-1 -: NB] = img[r - 2 + (k-1)/3][c - 2 + (k-1)%3];
        return w;
    endfunction

    // One clock: compare the outputs produced by the previous edge against the
    // model, then present the next input and predict its outcome.
    task automatic step(input logic v, input logic [NB-1:0] pix, input logic sof);
        @(negedge clk);
        chk("o_valid", {{(NB*K-1){1'b0}}, bus.o_valid}, {{(NB*K-1){1'b0}}, exp_valid});
        chk("o_last",  {{(NB*K-1){1'b0}}, bus.o_last},  {{(NB*K-1){1'b0}}, exp_last});
        if (exp_valid || win_known) chk("o_window", bus.o_window, exp_win);
        if (bus.o_valid === 1'b1) begin
            nwin++;
            cap.push_back(bus.o_window);
        end
        bus.i_valid = v;
        bus.i_pixel = pix;
`ifdef CONV_WINDOW_SOF_EN
        bus.i_sof = sof;
`endif
        exp_valid = 1'b0;
        exp_last  = 1'b0;
        if (v && rst_n) begin
            win_known = 1'b0;
`ifdef CONV_WINDOW_SOF_EN
            if (sof) begin mr = 0; mc = 0; end
`endif
            img[mr][mc] = pix;
            if (mr >= 2 && mc >= 2) begin
                exp_valid = 1'b1;
                exp_last  = (mr == H-1) && (mc == W-1);
                exp_win   = model_win(mr, mc);
            end
            mc++;
            if (mc == W) begin mc = 0; mr = (mr + 1) % H; end
        end
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_pixel = '0;
`ifdef CONV_WINDOW_SOF_EN
        bus.i_sof = 1'b0;
`endif
        mr = 0; mc = 0;
        exp_valid = 1'b0; exp_last = 1'b0; exp_win = '0; win_known = 1'b1;
        repeat (3) step(1'b0, '0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic send_frame(input int base, input int max_gap, input bit rnd, input bit sof_first);
        for (int p = 0; p < W*H; p++) begin
            logic [NB-1:0] px;
            px = rnd ? NB'($urandom) : NB'(base + p + 1);
            step(1'b1, px, sof_first && (p == 0));
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) step(1'b0, '0, 1'b0);
        end
    endtask

    task automatic flush();
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
    endtask

    initial begin
        int n0;
        do_reset();

        // Idle stream: nothing moves, window stays at its reset value.
        repeat (50) step(1'b0, '0, 1'b0);

        // Basic frame, back-to-back.
        n0 = nwin; cap.delete();
        send_frame(0, 0, 1'b0, 1'b0);
        flush();
        chk("basic_count", (NB*K)'(nwin - n0), (NB*K)'(4));
        if (cap.size() == 4) begin
            chk("basic_first", cap[0], 72'h010203_050607_090a0b);
            chk("basic_last",  cap[3], 72'h060708_0a0b0c_0e0f10);
        end else chk("basic_caps", (NB*K)'(cap.size()), (NB*K)'(4));

        // Gapped input: same frame, random idle cycles.
        n0 = nwin; cap.delete();
        send_frame(0, 3, 1'b0, 1'b0);
        flush();
        chk("gap_count", (NB*K)'(nwin - n0), (NB*K)'(4));
        if (cap.size() == 4) chk("gap_first", cap[0], 72'h010203_050607_090a0b);

        // Back-to-back frames, second offset by 100.
        n0 = nwin; cap.delete();
        send_frame(0, 0, 1'b0, 1'b0);
        send_frame(100, 0, 1'b0, 1'b0);
        flush();
        chk("b2b_count", (NB*K)'(nwin - n0), (NB*K)'(8));
        if (cap.size() == 8) chk("b2b_second_first", cap[4], 72'h656667_696a6b_6d6e6f);

        // Mid-frame reset after pixel 7, then a full frame.
        for (int p = 0; p < 7; p++) step(1'b1, NB'(p + 1), 1'b0);
        do_reset();
        n0 = nwin; cap.delete();
        send_frame(0, 0, 1'b0, 1'b0);
        flush();
        chk("rst_count", (NB*K)'(nwin - n0), (NB*K)'(4));
        if (cap.size() == 4) chk("rst_last", cap[3], 72'h060708_0a0b0c_0e0f10);

`ifdef CONV_WINDOW_SOF_EN
        // SOF resync: partial frame then a fresh frame flagged with i_sof.
        n0 = nwin; cap.delete();
        for (int p = 0; p < 6; p++) step(1'b1, NB'(p + 1), 1'b0);
        chk("sof_abort_count", (NB*K)'(nwin - n0), (NB*K)'(0));
        send_frame(0, 0, 1'b0, 1'b1);
        flush();
        chk("sof_count", (NB*K)'(nwin - n0), (NB*K)'(4));
        if (cap.size() == 4) begin
            chk("sof_first", cap[0], 72'h010203_050607_090a0b);
            chk("sof_last",  cap[3], 72'h060708_0a0b0c_0e0f10);
        end
`endif

        // Random pixels with random gaps, checked cycle by cycle by the model.
        for (int f = 0; f < 4; f++) begin
            n0 = nwin;
            send_frame(0, (f % 2) * 3, 1'b1, 1'b0);
            flush();
            chk("rand_count", (NB*K)'(nwin - n0), (NB*K)'(4));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
